uart_tx_frame: RTL

//  Parametrised UART transmitter for the serial TX path; successor to the 8-bit PISO shifter.

---
 rtl/uart_tx_frame_if.sv | 12 +
 rtl/uart_tx_frame.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_if.sv
// Word handshake between an upstream producer and the UART transmitter.
// The producer drives data_in/data_valid; the transmitter answers with data_ready.
interface uart_tx_frame_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] data_in;
   logic              data_valid;
   logic              data_ready;

   modport master (output data_in, output data_valid, input data_ready);
   modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Every serial bit is held for CLKS_PER_BIT clocks; the line idles high.
module uart_tx_frame #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 16,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic           clk,
   input  logic           rst,
   uart_tx_frame_if.slave bus,
   output logic           tx_out,
   output logic           busy
);

   // Reject illegal configurations at elaboration time.
   if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_tx_frame: DATA_W must be in 5..9");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_clks
      $error("uart_tx_frame: CLKS_PER_BIT must be >= 2");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_frame: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_tx_frame: STOP_BITS must be 1 or 2");
   end

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [3:0]        DATA_LAST = 4'(DATA_W - 1);
   localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [3:0]        bit_q, bit_d;     // data bit index in DATA, stop bit index in STOP
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;

   logic bit_end;
   logic ready;
   logic accept;

   // Ready only when idle or in the very last clock of the last stop bit,
   // so a waiting word can chain straight into the next start bit.
   assign bit_end = (baud_q == BAUD_LAST);
   assign ready   = (state_q == S_IDLE) ||
                    ((state_q == S_STOP) && bit_end && (bit_q == STOP_LAST));
   assign accept  = bus.data_valid && ready;

   assign bus.data_ready = ready;
   assign tx_out         = tx_q;
   assign busy           = busy_q;

   // Next-state, counter, shifter and registered-output computation.
   always_comb begin
      state_d = state_q;
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      tx_d    = tx_q;
      busy_d  = busy_q;

      if (state_q != S_IDLE) begin
         baud_d = bit_end ? '0 : baud_q + 1'b1;
      end

      case (state_q)
         S_START: begin
            if (bit_end) begin
               state_d = S_DATA;
               bit_d   = '0;
               tx_d    = shift_q[0];
            end
         end
         S_DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d = '0;
                  if (PARITY != 0) begin
                     state_d = S_PARITY;
                     tx_d    = par_q;
                  end else begin
                     state_d = S_STOP;
                     tx_d    = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
                  tx_d  = shift_q[1];
               end
            end
         end
         S_PARITY: begin
            if (bit_end) begin
               state_d = S_STOP;
               bit_d   = '0;
               tx_d    = 1'b1;
            end
         end
         S_STOP: begin
            if (bit_end) begin
               if (bit_q == STOP_LAST) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  bit_d   = '0;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
               tx_d = 1'b1;
            end
         end
         default: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
         end
      endcase

      // A new word (from IDLE or the final stop clock) starts a frame immediately.
      if (accept) begin
         state_d = S_START;
         baud_d  = '0;
         bit_d   = '0;
         shift_d = bus.data_in;
         par_d   = (PARITY == 2) ? ~^bus.data_in : ^bus.data_in;
         tx_d    = 1'b0;
         busy_d  = 1'b1;
      end
   end

   // State and output registers; reset abandons any frame and parks the line high.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
      end
   end

endmodule
